// File: rtl/code_match_round_pkg.sv
// rtl/code_match_round_pkg.sv - shared widths, state encodings and symbol constants
// The display logic decodes state_o with these same encodings.
package code_match_round_pkg;

  localparam int NUM_SYM = 3;
  localparam int SYM_W   = 2;
  localparam int ENT_W   = NUM_SYM * SYM_W;
  localparam int TIME_W  = 7;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ENTER  = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;

  localparam logic [SYM_W-1:0] SYM_ILLEGAL = 2'd3;

endpackage

// File: rtl/code_match_round_if.sv
// rtl/code_match_round_if.sv - game-round control/status bundle
// master drives the game inputs, slave is the round controller.
interface code_match_round_if #(
  parameter int SCORE_W = 8
);
  import code_match_round_pkg::*;

  logic                tick_1hz;
  logic [ENT_W-1:0]    rand_sym;
  logic                start;
  logic [SYM_W-1:0]    sym_in;
  logic                sym_valid;
  logic [ENT_W-1:0]    target;
  logic [ENT_W-1:0]    entry;
  logic [1:0]          entry_cnt;
  logic [SCORE_W-1:0]  score;
  logic [TIME_W-1:0]   time_left;
  logic [2:0]          state_o;
  logic                match_p;
  logic                miss_p;
  logic                game_over;

  modport master (
    output tick_1hz, rand_sym, start, sym_in, sym_valid,
    input  target, entry, entry_cnt, score, time_left, state_o, match_p, miss_p, game_over
  );

  modport slave (
    input  tick_1hz, rand_sym, start, sym_in, sym_valid,
    output target, entry, entry_cnt, score, time_left, state_o, match_p, miss_p, game_over
  );

endinterface

// File: rtl/sec_downcounter.sv
// rtl/sec_downcounter.sv - loadable 7-bit seconds down-counter with zero flag
// Load wins over enable; the count never wraps below zero.
module sec_downcounter #(
  parameter logic [6:0] RESET_VAL = 7'd60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [6:0] i_load_val,
  input  logic       i_en,
  output logic [6:0] o_count,
  output logic       o_zero
);

  logic [6:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 7'd0)) begin
      r_count <= r_count - 7'd1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == 7'd0);

endmodule

// File: rtl/code_match_round.sv
// rtl/code_match_round.sv - code-match game round FSM, entry register and comparator
// Round timer expiry preempts every other action in the active states.
module code_match_round
  import code_match_round_pkg::*;
#(
  parameter int ROUND_SECS  = 60,
  parameter int RESULT_SECS = 2,
  parameter int SCORE_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  code_match_round_if.slave bus
);

  localparam int RES_W = (RESULT_SECS < 1) ? 1 : $clog2(RESULT_SECS + 1);

  logic [2:0]         r_state;
  logic [ENT_W-1:0]   r_target;
  logic [ENT_W-1:0]   r_entry;
  logic [1:0]         r_entry_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [RES_W-1:0]   r_res_cnt;
  logic               r_match_p;
  logic               r_miss_p;
  logic               r_game_over;

  logic               w_active;
  logic               w_start_ok;
  logic               w_expire;
  logic               w_sym_ok;
  logic               w_zero;
  logic [TIME_W-1:0]  w_time_left;
  logic [RES_W-1:0]   w_res_nxt;

  assign w_active   = (r_state == ST_LOAD) || (r_state == ST_ENTER) ||
                      (r_state == ST_CHECK) || (r_state == ST_RESULT);
  assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
  // A zero-length game (time already 0 while active) ends at once as well.
  assign w_expire   = w_active && (w_zero || (bus.tick_1hz && (w_time_left == 7'd1)));
  assign w_sym_ok   = bus.sym_valid && (bus.sym_in != SYM_ILLEGAL);
  assign w_res_nxt  = r_res_cnt + 1'b1;

  sec_downcounter #(
    .RESET_VAL (7'(ROUND_SECS))
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_start_ok),
    .i_load_val (7'(ROUND_SECS)),
    .i_en       (bus.tick_1hz && w_active),
    .o_count    (w_time_left),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_entry     <= '0;
      r_entry_cnt <= 2'd0;
      r_score     <= '0;
      r_res_cnt   <= '0;
      r_match_p   <= 1'b0;
      r_miss_p    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_match_p <= 1'b0;
      r_miss_p  <= 1'b0;
      if (w_expire) begin
        r_state     <= ST_OVER;
        r_game_over <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_OVER: begin
            if (bus.start) begin
              r_state     <= ST_LOAD;
              r_score     <= '0;
              r_game_over <= 1'b0;
            end
          end
          ST_LOAD: begin
            r_target    <= bus.rand_sym;
            r_entry     <= '0;
            r_entry_cnt <= 2'd0;
            r_state     <= ST_ENTER;
          end
          ST_ENTER: begin
            if (w_sym_ok) begin
              for (int i = 0; i < NUM_SYM; i++) begin
                if (r_entry_cnt == 2'(i)) r_entry[i*SYM_W +: SYM_W] <= bus.sym_in;
              end
              r_entry_cnt <= r_entry_cnt + 2'd1;
              if (r_entry_cnt == 2'(NUM_SYM - 1)) r_state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (r_entry == r_target) begin
              r_match_p <= 1'b1;
              if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
            end else begin
              r_miss_p <= 1'b1;
            end
            r_res_cnt <= '0;
            r_state   <= ST_RESULT;
          end
          ST_RESULT: begin
            if (bus.tick_1hz) begin
              r_res_cnt <= w_res_nxt;
              if (w_res_nxt == RES_W'(RESULT_SECS)) r_state <= ST_LOAD;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.target    = r_target;
  assign bus.entry     = r_entry;
  assign bus.entry_cnt = r_entry_cnt;
  assign bus.score     = r_score;
  assign bus.time_left = w_time_left;
  assign bus.state_o   = r_state;
  assign bus.match_p   = r_match_p;
  assign bus.miss_p    = r_miss_p;
  assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_code_match_round.sv
// tb/tb_code_match_round.sv - directed bench for code_match_round
// Main DUT: 5 s game, 2 s result; second DUT: 2-bit score to reach saturation quickly.
module tb_code_match_round;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  code_match_round_if #(.SCORE_W(8)) bm ();
  code_match_round_if #(.SCORE_W(2)) bs ();

  code_match_round #(.ROUND_SECS(5), .RESULT_SECS(2), .SCORE_W(8)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bm)
  );

  code_match_round #(.ROUND_SECS(60), .RESULT_SECS(1), .SCORE_W(2)) u_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bs)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] s);
    bm.sym_in = s; bm.sym_valid = 1'b1;
    step();
    bm.sym_valid = 1'b0;
  endtask

  task automatic tick();
    bm.tick_1hz = 1'b1;
    step();
    bm.tick_1hz = 1'b0;
  endtask

  task automatic pulse_start();
    bm.start = 1'b1;
    step();
    bm.start = 1'b0;
  endtask

  task automatic press_s(input logic [1:0] s);
    bs.sym_in = s; bs.sym_valid = 1'b1;
    step();
    bs.sym_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bm.tick_1hz = 0; bm.rand_sym = 0; bm.start = 0; bm.sym_in = 0; bm.sym_valid = 0;
    bs.tick_1hz = 0; bs.rand_sym = 0; bs.start = 0; bs.sym_in = 0; bs.sym_valid = 0;
    step(); step();
    check_eq("rst_state", 32'(bm.state_o), 32'd0);
    check_eq("rst_time", 32'(bm.time_left), 32'd5);
    check_eq("rst_score", 32'(bm.score), 32'd0);
    check_eq("rst_target", 32'(bm.target), 32'd0);
    check_eq("rst_pulses", 32'({bm.match_p, bm.miss_p, bm.game_over}), 32'd0);
    rst = 1'b0;
    step();

    // Round 1: target 10_01_00, correct entry 0,1,2
    bm.rand_sym = 6'h24;
    pulse_start();
    check_eq("t1_load", 32'(bm.state_o), 32'd1);
    step();
    check_eq("t1_target", 32'(bm.target), 32'h24);
    check_eq("t1_enter", 32'(bm.state_o), 32'd2);
    press(2'd0); press(2'd1); press(2'd2);
    check_eq("t1_check", 32'(bm.state_o), 32'd3);
    check_eq("t1_entry", 32'(bm.entry), 32'h24);
    check_eq("t1_cnt", 32'(bm.entry_cnt), 32'd3);
    check_eq("t1_match_early", 32'(bm.match_p), 32'd0);
    step();
    check_eq("t1_match", 32'(bm.match_p), 32'd1);
    check_eq("t1_miss", 32'(bm.miss_p), 32'd0);
    check_eq("t1_score", 32'(bm.score), 32'd1);
    check_eq("t1_result", 32'(bm.state_o), 32'd4);
    step();
    check_eq("t1_match_off", 32'(bm.match_p), 32'd0);

    // Result hold: 2 ticks, then same target reloads; wrong entry 0,0,2
    tick();
    check_eq("t2_hold", 32'(bm.state_o), 32'd4);
    check_eq("t2_time4", 32'(bm.time_left), 32'd4);
    tick();
    check_eq("t2_reload", 32'(bm.state_o), 32'd1);
    check_eq("t2_time3", 32'(bm.time_left), 32'd3);
    step();
    check_eq("t2_target", 32'(bm.target), 32'h24);
    check_eq("t2_entry_clr", 32'(bm.entry), 32'd0);
    press(2'd0); press(2'd0); press(2'd2);
    check_eq("t2_entry", 32'(bm.entry), 32'h20);
    step();
    check_eq("t2_miss", 32'(bm.miss_p), 32'd1);
    check_eq("t2_match", 32'(bm.match_p), 32'd0);
    check_eq("t2_score", 32'(bm.score), 32'd1);
    press(2'd1);
    check_eq("t2_res_ignore", 32'(bm.entry_cnt), 32'd3);
    check_eq("t2_res_state", 32'(bm.state_o), 32'd4);
    bm.rand_sym = 6'h09;
    tick(); tick();
    check_eq("t2_time1", 32'(bm.time_left), 32'd1);
    step();
    check_eq("t2_recapture", 32'(bm.target), 32'h09);

    // Illegal symbols dropped, start ignored while active
    pulse_start();
    check_eq("t3_start_ign", 32'(bm.state_o), 32'd2);
    press(2'd3); press(2'd3);
    check_eq("t3_ill_cnt", 32'(bm.entry_cnt), 32'd0);
    press(2'd1);
    check_eq("t3_cnt1", 32'(bm.entry_cnt), 32'd1);
    press(2'd3);
    check_eq("t3_ill_cnt1", 32'(bm.entry_cnt), 32'd1);
    press(2'd2);
    check_eq("t3_cnt2", 32'(bm.entry_cnt), 32'd2);
    check_eq("t3_entry", 32'(bm.entry), 32'h09);

    // Expiry with final symbol in the same cycle
    bm.tick_1hz = 1'b1; bm.sym_in = 2'd0; bm.sym_valid = 1'b1;
    step();
    bm.tick_1hz = 1'b0; bm.sym_valid = 1'b0;
    check_eq("t5_over", 32'(bm.state_o), 32'd5);
    check_eq("t5_time0", 32'(bm.time_left), 32'd0);
    check_eq("t5_game_over", 32'(bm.game_over), 32'd1);
    check_eq("t5_cnt_hold", 32'(bm.entry_cnt), 32'd2);
    check_eq("t5_no_pulse0", 32'({bm.match_p, bm.miss_p}), 32'd0);
    step();
    check_eq("t5_no_pulse1", 32'({bm.match_p, bm.miss_p}), 32'd0);
    check_eq("t5_score", 32'(bm.score), 32'd1);

    // Restart from OVER, run the full 5 s without entries
    pulse_start();
    check_eq("t4_load", 32'(bm.state_o), 32'd1);
    check_eq("t4_score0", 32'(bm.score), 32'd0);
    check_eq("t4_time5", 32'(bm.time_left), 32'd5);
    check_eq("t4_go_clr", 32'(bm.game_over), 32'd0);
    step();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("t4_time_%0d", k), 32'(bm.time_left), 32'(5 - k));
    end
    check_eq("t4_over", 32'(bm.state_o), 32'd5);
    check_eq("t4_game_over", 32'(bm.game_over), 32'd1);
    tick();
    check_eq("t4_over_hold", 32'(bm.time_left), 32'd0);

    // Asynchronous reset mid-ENTER
    pulse_start();
    step();
    press(2'd2);
    check_eq("t6_pre_cnt", 32'(bm.entry_cnt), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_state", 32'(bm.state_o), 32'd0);
    check_eq("t6_cnt", 32'(bm.entry_cnt), 32'd0);
    check_eq("t6_entry", 32'(bm.entry), 32'd0);
    check_eq("t6_target", 32'(bm.target), 32'd0);
    check_eq("t6_time", 32'(bm.time_left), 32'd5);
    step();
    rst = 1'b0;
    step();

    // Saturation on the 2-bit score instance
    bs.rand_sym = 6'h24;
    bs.start = 1'b1;
    step();
    bs.start = 1'b0;
    step();
    for (int r = 1; r <= 4; r++) begin
      press_s(2'd0); press_s(2'd1); press_s(2'd2);
      step();
      check_eq($sformatf("sat_match_%0d", r), 32'(bs.match_p), 32'd1);
      check_eq($sformatf("sat_score_%0d", r), 32'(bs.score), 32'((r > 3) ? 3 : r));
      bs.tick_1hz = 1'b1;
      step();
      bs.tick_1hz = 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
